// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator for a byte-addressed big-endian memory, with read-modify-write for sub-word stores.
// Optional alignment faulting is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_stall,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rspRdata;
  logic                r_rspErr;

  logic                w_accept;
  logic [ADDR_W:0]     w_lastByte;
  logic                w_rangeFault;
  logic                w_alignFault;
  logic                w_fault;
  logic [DATA_W-1:0]   w_loadData;
  logic [DATA_W-1:0]   w_mergeData;

  assign w_accept = i_req_valid && (r_state == S_IDLE);

  // Range check is one bit wider than the address so a huge address cannot wrap into range.
  assign w_lastByte   = {1'b0, i_req_addr} + (ADDR_W+1)'(3);
  assign w_rangeFault = (w_lastByte >= (ADDR_W+1)'(MEM_BYTES));

`ifdef MEM_ALIGN_CHECK_EN
  assign w_alignFault = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                        ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
  assign w_alignFault = 1'b0;
`endif

  assign w_fault = (i_req_size == 2'b11) || w_rangeFault || w_alignFault;

  always_comb begin
    w_loadData  = i_mem_rdata;
    w_mergeData = {r_wdata[15:0], i_mem_rdata[15:0]};
    case (r_size)
      2'b00: w_loadData = {{(DATA_W-8){r_signed & i_mem_rdata[31]}}, i_mem_rdata[31:24]};
      2'b01: w_loadData = {{(DATA_W-16){r_signed & i_mem_rdata[31]}}, i_mem_rdata[31:16]};
      default: w_loadData = i_mem_rdata;
    endcase
    if (r_size == 2'b00) begin
      w_mergeData = {r_wdata[7:0], i_mem_rdata[23:0]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault)                 w_nextState = S_RESP;
          else if (!i_req_we)          w_nextState = S_LOAD;
          else if (i_req_size == 2'b10) w_nextState = S_STORE;
          else                         w_nextState = S_RMW_RD;
        end
      end
      S_LOAD:   w_nextState = S_RESP;
      S_STORE:  w_nextState = S_RESP;
      S_RMW_RD: w_nextState = S_RMW_WR;
      S_RMW_WR: w_nextState = S_RESP;
      S_RESP:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // r_wdata doubles as the write buffer: RMW_RD overwrites it with the merged word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we       <= i_req_we;
            r_size     <= i_req_size;
            r_signed   <= i_req_signed;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            r_rspRdata <= '0;
            r_rspErr   <= w_fault;
          end
        end
        S_LOAD:   r_rspRdata <= w_loadData;
        S_RMW_RD: r_wdata    <= w_mergeData;
        default: ;
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_stall     = ~o_req_ready;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_err   = o_rsp_valid & r_rspErr;
  assign o_rsp_rdata = r_rspRdata;
  assign o_mem_read  = (r_state == S_LOAD)  || (r_state == S_RMW_RD);
  assign o_mem_write = (r_state == S_STORE) || (r_state == S_RMW_WR);
  assign o_mem_addr  = (o_mem_read || o_mem_write) ? r_addr : '0;
  assign o_mem_wdata = o_mem_write ? r_wdata : '0;

endmodule
